// File: rtl/stp_pkg.sv
// Shared defaults for the stepper-motor step-period timebase.
package stp_pkg;

    localparam int unsigned STP_CNT_W  = 32;
    localparam int unsigned STP_CLK_HZ = 50_000_000;

    typedef logic [STP_CNT_W-1:0] stp_cnt_t;

endpackage

// File: rtl/stp_counter.sv
// Step-period up-counter with synchronous active-low clear and wrap pulse.
// Optional sticky overflow flag `ovf` when STP_COUNTER_OVF_EN is defined.
module stp_counter
    import stp_pkg::*;
#(
    parameter int unsigned WIDTH    = STP_CNT_W,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reset1_n,
    input  logic             en,
    output logic [WIDTH-1:0] q,
`ifdef STP_COUNTER_OVF_EN
    output logic             ovf,
`endif
    output logic             wrap
);

    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             all_ones;

    assign all_ones = &q;

`ifdef STP_COUNTER_OVF_EN
    logic ovf_nxt;
`endif

    always_comb begin
        q_nxt    = q;
        wrap_nxt = 1'b0;
`ifdef STP_COUNTER_OVF_EN
        ovf_nxt  = ovf;
`endif
        // Clear beats enable, including at all-ones, so no wrap on a clear.
        if (!reset1_n) begin
            q_nxt = '0;
`ifdef STP_COUNTER_OVF_EN
            ovf_nxt = 1'b0;
`endif
        end else if (en) begin
            if (all_ones) begin
`ifdef STP_COUNTER_OVF_EN
                ovf_nxt = 1'b1;
`endif
                if (!SATURATE) begin
                    q_nxt    = '0;
                    wrap_nxt = 1'b1;
                end
            end else begin
                q_nxt = q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q    <= '0;
            wrap <= 1'b0;
`ifdef STP_COUNTER_OVF_EN
            ovf  <= 1'b0;
`endif
        end else begin
            q    <= q_nxt;
            wrap <= wrap_nxt;
`ifdef STP_COUNTER_OVF_EN
            ovf  <= ovf_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_stp_counter.sv
// Self-checking bench for stp_counter: directed scenarios plus randomized
// stimulus against an arithmetic reference model (three parameterisations).
module tb_stp_counter;

    logic clk;
    logic reset;
    logic reset1_n;
    logic en;

    logic [31:0] q32;
    logic [3:0]  q4;
    logic [3:0]  q4s;
    logic        w32, w4, w4s;
`ifdef STP_COUNTER_OVF_EN
    logic        o32, o4, o4s;
`endif

    int unsigned errors = 0;
    int unsigned checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    stp_counter #(.WIDTH(32), .SATURATE(1'b0)) u_d32 (
        .clk(clk), .reset(reset), .reset1_n(reset1_n), .en(en),
        .q(q32),
`ifdef STP_COUNTER_OVF_EN
        .ovf(o32),
`endif
        .wrap(w32)
    );

    stp_counter #(.WIDTH(4), .SATURATE(1'b0)) u_d4 (
        .clk(clk), .reset(reset), .reset1_n(reset1_n), .en(en),
        .q(q4),
`ifdef STP_COUNTER_OVF_EN
        .ovf(o4),
`endif
        .wrap(w4)
    );

    stp_counter #(.WIDTH(4), .SATURATE(1'b1)) u_d4s (
        .clk(clk), .reset(reset), .reset1_n(reset1_n), .en(en),
        .q(q4s),
`ifdef STP_COUNTER_OVF_EN
        .ovf(o4s),
`endif
        .wrap(w4s)
    );

    // Reference model: counts as integers modulo 2^W
    int unsigned       mw_width [3] = '{32, 4, 4};
    bit                m_sat    [3] = '{1'b0, 1'b0, 1'b1};
    longint unsigned   m_q      [3];
    bit                m_wrap   [3];
    bit                m_ovf    [3];

    always @(posedge clk or posedge reset) begin
        for (int i = 0; i < 3; i++) begin
            longint unsigned maxv;
            maxv = (64'd1 << mw_width[i]) - 64'd1;
            if (reset) begin
                m_q[i]    <= 0;
                m_wrap[i] <= 1'b0;
                m_ovf[i]  <= 1'b0;
            end else if (!reset1_n) begin
                m_q[i]    <= 0;
                m_wrap[i] <= 1'b0;
                m_ovf[i]  <= 1'b0;
            end else if (en) begin
                if (m_q[i] == maxv) begin
                    m_ovf[i]  <= 1'b1;
                    m_wrap[i] <= !m_sat[i];
                    m_q[i]    <= m_sat[i] ? maxv : 0;
                end else begin
                    m_q[i]    <= m_q[i] + 1;
                    m_wrap[i] <= 1'b0;
                end
            end else begin
                m_wrap[i] <= 1'b0;
            end
        end
    end

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, all DUT outputs against the model
    always @(negedge clk) begin
        check("model_q32",   64'(q32), m_q[0]);
        check("model_q4",    64'(q4),  m_q[1]);
        check("model_q4s",   64'(q4s), m_q[2]);
        check("model_wrap32", 64'(w32), 64'(m_wrap[0]));
        check("model_wrap4",  64'(w4),  64'(m_wrap[1]));
        check("model_wrap4s", 64'(w4s), 64'(m_wrap[2]));
`ifdef STP_COUNTER_OVF_EN
        check("model_ovf32", 64'(o32), 64'(m_ovf[0]));
        check("model_ovf4",  64'(o4),  64'(m_ovf[1]));
        check("model_ovf4s", 64'(o4s), 64'(m_ovf[2]));
`endif
    end

    // Drive inputs just after the falling edge, return 1 time unit after the rising edge
    task automatic step(input logic e, input logic c);
        @(negedge clk);
        #1;
        en       = e;
        reset1_n = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned cur;
        reset    = 1'b1;
        en       = 1'b0;
        reset1_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_q32", 64'(q32), 64'd0);
        check("reset_wrap32", 64'(w32), 64'd0);
        reset = 1'b0;

        // Async reset mid-count at q=17
        repeat (17) step(1'b1, 1'b1);
        check("count_to_17", 64'(q32), 64'd17);
        #2 reset = 1'b1;
        #1;
        check("async_reset_q", 64'(q32), 64'd0);
        check("async_reset_wrap", 64'(w32), 64'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            check("reset_hold_q", 64'(q32), 64'd0);
        end
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step(1'b1, 1'b1);
            check("post_reset_count", 64'(q32), 64'(i));
        end

        // Enable gating
        step(1'b0, 1'b0);
        check("clear_en0", 64'(q32), 64'd0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1);
            check("gate_count", 64'(q32), 64'(i));
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1);
            check("gate_hold", 64'(q32), 64'd5);
        end
        step(1'b1, 1'b1);
        check("gate_resume6", 64'(q32), 64'd6);
        step(1'b1, 1'b1);
        check("gate_resume7", 64'(q32), 64'd7);

        // Clear priority over enable
        repeat (2) step(1'b1, 1'b1);
        check("reach_9", 64'(q32), 64'd9);
        step(1'b1, 1'b0);
        check("clear_over_en", 64'(q32), 64'd0);
        repeat (3) step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        check("clear_en_low", 64'(q32), 64'd0);

        // Clear-on-compare with L=4: sawtooth of period 5
        cur = 0;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, cur < 4);
            cur = (cur < 4) ? cur + 1 : 0;
            check("saw_q", 64'(q32), 64'(cur));
        end

        // Wrap / saturate at WIDTH=4
        step(1'b0, 1'b0);
        repeat (15) step(1'b1, 1'b1);
        check("w4_at_15", 64'(q4), 64'd15);
        check("w4s_at_15", 64'(q4s), 64'd15);
        check("w4_no_wrap_yet", 64'(w4), 64'd0);
        step(1'b1, 1'b1);
        check("w4_wrapped_q", 64'(q4), 64'd0);
        check("w4_wrap_pulse", 64'(w4), 64'd1);
        check("w4s_sticks", 64'(q4s), 64'd15);
        check("w4s_no_wrap", 64'(w4s), 64'd0);
        check("w32_no_wrap", 64'(w32), 64'd0);
`ifdef STP_COUNTER_OVF_EN
        check("ovf4_set", 64'(o4), 64'd1);
        check("ovf4s_set", 64'(o4s), 64'd1);
        check("ovf32_clear", 64'(o32), 64'd0);
`endif
        step(1'b1, 1'b1);
        check("w4_after_wrap_q", 64'(q4), 64'd1);
        check("w4_wrap_one_cycle", 64'(w4), 64'd0);
        check("w4s_still_15", 64'(q4s), 64'd15);
`ifdef STP_COUNTER_OVF_EN
        check("ovf4_sticky", 64'(o4), 64'd1);
`endif
        step(1'b1, 1'b0);
        check("w4_clear_q", 64'(q4), 64'd0);
        check("w4s_clear_q", 64'(q4s), 64'd0);
`ifdef STP_COUNTER_OVF_EN
        check("ovf4_cleared", 64'(o4), 64'd0);
        check("ovf4s_cleared", 64'(o4s), 64'd0);
`endif

        // Randomized phase; occasional async reset pulses asserted between edges
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            en       = ($urandom_range(0, 3) != 0);
            reset1_n = ($urandom_range(0, 40) != 0);
            reset    = ($urandom_range(0, 150) == 0);
            @(posedge clk);
        end
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
